// File: rtl/pe_row_sched_if.sv
// Handshake bundle between the PE row sequencer and its weight buffer,
// input buffer, PE row and downstream consumer.
interface pe_row_sched_if;
  logic w_req;
  logic w_valid;
  logic w_load;
  logic pix_valid;
  logic pix_ready;
  logic pe_en;
  logic out_valid;
  logic out_last;
  logic out_ready;

  modport master (
    output w_req, w_load, pix_ready, pe_en, out_valid, out_last,
    input  w_valid, pix_valid, out_ready
  );

  modport slave (
    input  w_req, w_load, pix_ready, pe_en, out_valid, out_last,
    output w_valid, pix_valid, out_ready
  );
endinterface

// File: rtl/pe_row_sched.sv
// Tile-pass sequencer for one PE row: weight fetch, pixel streaming,
// product tracking through the PE pipeline and downstream handshake.
//
//  state  | meaning
//  IDLE   | waiting for start
//  LOAD_W | requesting the tile's weight vector
//  STREAM | accepting pixel vectors until cfg_len taken
//  DRAIN  | no more pixels, emptying the PE pipeline
//  DONE   | one-cycle completion pulse
module pe_row_sched #(
  parameter int LANES  = 16,
  parameter int CNT_W  = 10,
  parameter int PE_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] cfg_len_i,
  output logic             busy_o,
  output logic             done_o,
  pe_row_sched_if.master   row_if
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_W = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Control is lane-uniform, so LANES only documents the row width.
  if (PE_LAT < 1 || LANES < 1) begin : g_bad_params
  end

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PE_LAT-1:0] vld_q, vld_d;
  logic [PE_LAT-1:0] lst_q, lst_d;

  logic out_valid;
  logic stall;
  logic pe_en;
  logic pix_ready;
  logic accept;
  logic is_last;
  logic w_req;

  always_comb begin
    out_valid = vld_q[PE_LAT-1];
    stall     = out_valid & ~row_if.out_ready;
    pe_en     = ((state_q == S_STREAM) || (state_q == S_DRAIN)) & ~stall;
    pix_ready = (state_q == S_STREAM) & ~stall;
    accept    = pix_ready & row_if.pix_valid;
    is_last   = (cnt_q == (len_q - CNT_W'(1)));
    w_req     = (state_q == S_LOAD_W);
  end

  // Pipe tokens move only with the PE row, so a stall freezes the output.
  always_comb begin
    vld_d = vld_q;
    lst_d = lst_q;
    if (pe_en) begin
      vld_d[0] = accept;
      lst_d[0] = accept & is_last;
      for (int i = 1; i < PE_LAT; i++) begin
        vld_d[i] = vld_q[i-1];
        lst_d[i] = lst_q[i-1];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (cfg_len_i == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD_W;
            len_d   = cfg_len_i;
            cnt_d   = '0;
          end
        end
      end
      S_LOAD_W: begin
        if (row_if.w_valid) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (is_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_valid && lst_q[PE_LAT-1] && row_if.out_ready) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= '0;
      lst_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      lst_q   <= lst_d;
    end
  end

  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = (state_q == S_DONE);
  assign row_if.w_req     = w_req;
  assign row_if.w_load    = w_req & row_if.w_valid;
  assign row_if.pix_ready = pix_ready;
  assign row_if.pe_en     = pe_en;
  assign row_if.out_valid = out_valid;
  assign row_if.out_last  = lst_q[PE_LAT-1];

endmodule

// File: tb/tb_pe_row_sched.sv
// Bench for pe_row_sched: PE_LAT=1 and PE_LAT=3 rows driven in lockstep and
// checked every cycle against a token-level model of the tile pass.
module tb_pe_row_sched;
  localparam int CNT_W = 10;
  localparam int M_IDLE = 0, M_LOAD = 1, M_ST = 2, M_DR = 3, M_DONE = 4;

  typedef struct {
    int inst;
    int age;
    bit last;
  } tok_t;

  logic clk = 1'b0;
  logic rst, start, w_valid, pix_valid, out_ready;
  logic [CNT_W-1:0] cfg_len;
  logic busy0, done0, busy1, done1;
  logic [7:0] obs [2];

  pe_row_sched_if if0 ();
  pe_row_sched_if if1 ();

  assign if0.w_valid = w_valid;
  assign if0.pix_valid = pix_valid;
  assign if0.out_ready = out_ready;
  assign if1.w_valid = w_valid;
  assign if1.pix_valid = pix_valid;
  assign if1.out_ready = out_ready;

  pe_row_sched #(.LANES(16), .CNT_W(CNT_W), .PE_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .start_i(start), .cfg_len_i(cfg_len),
    .busy_o(busy0), .done_o(done0), .row_if(if0.master));

  pe_row_sched #(.LANES(16), .CNT_W(CNT_W), .PE_LAT(3)) dut1 (
    .clk(clk), .rst(rst), .start_i(start), .cfg_len_i(cfg_len),
    .busy_o(busy1), .done_o(done1), .row_if(if1.master));

  assign obs[0] = {busy0, done0, if0.w_req, if0.w_load, if0.pix_ready,
                   if0.pe_en, if0.out_valid, if0.out_last};
  assign obs[1] = {busy1, done1, if1.w_req, if1.w_load, if1.pix_ready,
                   if1.pe_en, if1.out_valid, if1.out_last};

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc_n = 0, tcnt = 0;
  int xfer [2], dones [2], wreqs [2], accs [2], done_at [2];
  int m_ph [2], m_len [2], m_cnt [2];
  tok_t tq [$];
  bit wl_prev;
  logic [7:0] pat8 = 8'b11011001;

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic bit model_ov(int k);
    bit r = 1'b0;
    foreach (tq[i]) if (tq[i].inst == k && tq[i].age == lat_of(k)) r = 1'b1;
    return r;
  endfunction

  function automatic bit model_ol(int k);
    bit r = 1'b0;
    foreach (tq[i]) if (tq[i].inst == k && tq[i].age == lat_of(k)) r = tq[i].last;
    return r;
  endfunction

  // {busy, done, w_req, w_load, pix_ready, pe_en, out_valid, out_last}
  function automatic logic [7:0] exp_outs(int k);
    bit ov = model_ov(k);
    bit stall = ov && !out_ready;
    bit st = (m_ph[k] == M_ST);
    bit dr = (m_ph[k] == M_DR);
    if (rst) return 8'h00;
    return {m_ph[k] != M_IDLE, m_ph[k] == M_DONE, m_ph[k] == M_LOAD,
            (m_ph[k] == M_LOAD) && w_valid, st && !stall, (st || dr) && !stall,
            ov, ov && model_ol(k)};
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = M_IDLE; m_len[k] = 0; m_cnt[k] = 0;
    end
    tq.delete();
  endfunction

  function automatic void model_update(int k);
    bit ov = model_ov(k);
    bit ol = model_ol(k);
    bit stall = ov && !out_ready;
    bit pe = (m_ph[k] == M_ST || m_ph[k] == M_DR) && !stall;
    bit acc = (m_ph[k] == M_ST) && !stall && pix_valid;
    bit last_out = 1'b0;
    int idx = -1;
    tok_t t;
    if (pe) begin
      if (ov) begin
        foreach (tq[i]) if (tq[i].inst == k && tq[i].age == lat_of(k)) idx = i;
        tq.delete(idx);
        last_out = ol;
      end
      for (int i = 0; i < tq.size(); i++) begin
        if (tq[i].inst == k) begin
          t = tq[i]; t.age = t.age + 1; tq[i] = t;
        end
      end
      if (acc) begin
        t.inst = k; t.age = 1; t.last = (m_cnt[k] == m_len[k] - 1);
        tq.push_back(t);
      end
    end
    case (m_ph[k])
      M_IDLE: if (start) begin
        if (cfg_len == 0) m_ph[k] = M_DONE;
        else begin m_ph[k] = M_LOAD; m_len[k] = int'(cfg_len); m_cnt[k] = 0; end
      end
      M_LOAD: if (w_valid) m_ph[k] = M_ST;
      M_ST: if (acc) begin
        if (m_cnt[k] == m_len[k] - 1) m_ph[k] = M_DR;
        m_cnt[k]++;
      end
      M_DR: if (last_out) m_ph[k] = M_DONE;
      default: m_ph[k] = M_IDLE;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic cyc();
    logic [7:0] e;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      e = exp_outs(k);
      n_cmp++;
      assert (obs[k] === e) else begin
        n_bad++;
        $error("FAIL outs%0d cyc=%0d observed=%b expected=%b", k, cyc_n, obs[k], e);
      end
      if (obs[k][1] && out_ready) xfer[k]++;
      if (obs[k][6]) begin dones[k]++; done_at[k] = tcnt; end
      if (obs[k][5]) wreqs[k]++;
      if (obs[k][3] && pix_valid) accs[k]++;
    end
    @(posedge clk);
    if (rst) model_reset();
    else begin model_update(0); model_update(1); end
    cyc_n++;
    tcnt++;
    #1;
  endtask

  task automatic clr_counts();
    for (int k = 0; k < 2; k++) begin
      xfer[k] = 0; dones[k] = 0; wreqs[k] = 0; accs[k] = 0; done_at[k] = -1;
    end
    tcnt = 0;
    wl_prev = 1'b0;
  endtask

  task automatic drive_wvalid();
    w_valid = (m_ph[0] == M_LOAD) && wl_prev;
    wl_prev = (m_ph[0] == M_LOAD);
  endtask

  // pmode: 0 pix always, 1 fixed bubble pattern, 2 random
  // rmode: 0 always ready, 1 three-cycle stall on first product, 2 random
  task automatic run_tile(input string tag, input int len, input int pmode, input int rmode,
                          input bit restart, input int exp_d0, input int exp_d1);
    int t = 1, scnt = 0, stall_left = 0;
    bit stalled_once = 1'b0;
    clr_counts();
    start = 1'b1; cfg_len = CNT_W'(len);
    pix_valid = 1'b0; out_ready = 1'b1; w_valid = 1'b0;
    cyc();
    cfg_len = CNT_W'($urandom);
    while (!(m_ph[0] == M_IDLE && m_ph[1] == M_IDLE) && t < 3000) begin
      start = (t == 1) && restart;
      if (start) cfg_len = 3;
      drive_wvalid();
      case (pmode)
        0: pix_valid = 1'b1;
        1: pix_valid = pat8[scnt % 8];
        default: pix_valid = ($urandom_range(0, 3) != 0);
      endcase
      if (m_ph[0] == M_ST) scnt++;
      case (rmode)
        0: out_ready = 1'b1;
        1: begin
          if (!stalled_once && model_ov(0)) begin stall_left = 3; stalled_once = 1'b1; end
          out_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      cyc();
      t++;
    end
    chk({tag, "_timeout"}, 32'(t < 3000), 1);
    start = 1'b0; pix_valid = 1'b0; out_ready = 1'b1; w_valid = 1'b0;
    cyc();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_xfer%0d", tag, k), xfer[k], len);
      chk($sformatf("%s_accepts%0d", tag, k), accs[k], len);
      chk($sformatf("%s_dones%0d", tag, k), dones[k], 1);
      if (len == 0) chk($sformatf("%s_wreq%0d", tag, k), wreqs[k], 0);
    end
    if (exp_d0 >= 0) chk({tag, "_donecyc0"}, done_at[0], exp_d0);
    if (exp_d1 >= 0) chk({tag, "_donecyc1"}, done_at[1], exp_d1);
  endtask

  initial begin
    int t;
    model_reset();
    clr_counts();
    rst = 1'b1; start = 1'b1; cfg_len = 1;
    w_valid = 1'b0; pix_valid = 1'b0; out_ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    run_tile("reset_len1", 1, 0, 0, 1'b0, 5, 7);

    run_tile("basic", 4, 0, 0, 1'b0, 8, 10);
    run_tile("backpressure", 3, 0, 1, 1'b0, -1, -1);
    run_tile("bubbles", 5, 1, 0, 1'b0, -1, -1);
    run_tile("zero_len", 0, 0, 0, 1'b1, 1, 1);

    // Abort after two of eight accepted pixels.
    clr_counts();
    start = 1'b1; cfg_len = 8; pix_valid = 1'b1; out_ready = 1'b1; w_valid = 1'b0;
    cyc();
    start = 1'b0;
    t = 0;
    while (m_cnt[0] < 2 && t < 100) begin
      drive_wvalid();
      cyc();
      t++;
    end
    chk("abort_reach", m_ph[0], M_ST);
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    w_valid = 1'b0; pix_valid = 1'b0;
    cyc();
    chk("abort_nodone0", dones[0], 0);
    chk("abort_nodone1", dones[1], 0);
    run_tile("after_abort", 2, 0, 0, 1'b0, 6, 8);

    for (int i = 0; i < 20; i++)
      run_tile($sformatf("rand%0d", i), $urandom_range(1, 12), 2, 2, 1'b0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
